// File: rtl/mux_rr_reg.sv
// NCH-to-1 registered channel mux with valid/ready on every port.
// Round-robin or fixed-priority grant feeding a one-entry output register.
module mux_rr_reg #(
  parameter int WIDTH     = 16,
  parameter int NCH       = 4,
  parameter int PRIO_MODE = 0,
  localparam int SELW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NCH-1:0]         in_valid,
  input  logic [NCH*WIDTH-1:0]   in_data,
  output logic [NCH-1:0]         in_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [SELW-1:0]        out_sel,
  input  logic                   out_ready,
  output logic [15:0]            xfer_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [SELW-1:0]   out_sel_q, out_sel_d;
  logic [SELW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [15:0]       xfer_cnt_q, xfer_cnt_d;

  logic              load_en;
  logic              gnt_found;
  logic              accept;
  logic              drain;
  logic [SELW-1:0]   gnt_idx;
  logic [SELW-1:0]   cand;
  logic [WIDTH-1:0]  gnt_word;

  // Search starts at rr_ptr; fixed mode keeps rr_ptr at 0 so
  // the same scan yields lowest-index-wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NCH; k++) begin
      cand = SELW'((int'(rr_ptr_q) + k) % NCH);
      if (!gnt_found && in_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    gnt_word = '0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt_idx == SELW'(i)) begin
        gnt_word = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign load_en = (state_q == EMPTY) | out_ready;
  assign accept  = rst_n & load_en & gnt_found;
  assign drain   = (state_q == FULL) & out_ready;

  always_comb begin
    in_ready = '0;
    if (accept) begin
      in_ready = NCH'(1) << gnt_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = FULL;
    end else if (drain) begin
      state_d = EMPTY;
    end
  end

  always_comb begin
    out_valid = (state_q == FULL);
    out_data  = out_data_q;
    out_sel   = out_sel_q;
    xfer_cnt  = xfer_cnt_q;
  end

  always_comb begin
    out_data_d = out_data_q;
    out_sel_d  = out_sel_q;
    rr_ptr_d   = rr_ptr_q;
    xfer_cnt_d = xfer_cnt_q;
    if (accept) begin
      out_data_d = gnt_word;
      out_sel_d  = gnt_idx;
      if (PRIO_MODE == 0) begin
        rr_ptr_d = (gnt_idx == SELW'(NCH - 1)) ?
                   '0 : gnt_idx + SELW'(1);
      end
    end
    if (drain && xfer_cnt_q != 16'hFFFF) begin
      xfer_cnt_d = xfer_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q <= '0;
      out_sel_q  <= '0;
      rr_ptr_q   <= '0;
      xfer_cnt_q <= '0;
    end else begin
      out_data_q <= out_data_d;
      out_sel_q  <= out_sel_d;
      rr_ptr_q   <= rr_ptr_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

endmodule

// File: tb/tb_mux_rr_reg.sv
// Bench for mux_rr_reg: one round-robin and one fixed-priority instance
// driven in parallel, checked against vector tables and a reference model.
module tb_mux_rr_reg;

  localparam int NCH = 4;
  localparam int W   = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NCH-1:0]  in_valid;
  logic [NCH*W-1:0] in_data;
  logic            out_ready;

  logic [NCH-1:0]  rdy_rr, rdy_fx;
  logic            ov_rr, ov_fx;
  logic [W-1:0]    od_rr, od_fx;
  logic [1:0]      os_rr, os_fx;
  logic [15:0]     cnt_rr, cnt_fx;

  always #5 clk = ~clk;

  mux_rr_reg #(.WIDTH(W), .NCH(NCH), .PRIO_MODE(0)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_rr),
    .out_valid(ov_rr), .out_data(od_rr), .out_sel(os_rr),
    .out_ready(out_ready), .xfer_cnt(cnt_rr)
  );

  mux_rr_reg #(.WIDTH(W), .NCH(NCH), .PRIO_MODE(1)) dut_fx (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_fx),
    .out_valid(ov_fx), .out_data(od_fx), .out_sel(os_fx),
    .out_ready(out_ready), .xfer_cnt(cnt_fx)
  );

  int passed = 0;
  int total  = 0;
  bit mchk   = 1'b0;

  // Reference model: index 0 = round-robin, 1 = fixed priority
  bit          mv   [2];
  logic [15:0] md   [2];
  int          ms   [2];
  int          mptr [2];
  int          mcnt [2];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
  endtask

  function automatic int exp_gnt(int m);
    if (!rst_n) return -1;
    if (mv[m] && !out_ready) return -1;
    for (int k = 0; k < NCH; k++) begin
      int j;
      j = (mptr[m] + k) % NCH;
      if (in_valid[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_rdy(int m);
    int g;
    g = exp_gnt(m);
    return (g < 0) ? 4'h0 : 4'(1 << g);
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mv[m] = 0; md[m] = '0; ms[m] = 0; mptr[m] = 0; mcnt[m] = 0;
    end
  endtask

  task automatic model_upd();
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int m = 0; m < 2; m++) begin
        int g;
        bit drained;
        g = exp_gnt(m);
        drained = mv[m] && out_ready;
        if (drained && mcnt[m] < 65535) mcnt[m]++;
        if (g >= 0) begin
          mv[m] = 1;
          md[m] = in_data[g*W +: W];
          ms[m] = g;
          if (m == 0) mptr[m] = (g + 1) % NCH;
        end else if (drained) begin
          mv[m] = 0;
        end
      end
    end
  endtask

  task automatic chk_dut(int m, logic [3:0] rdy, logic ov,
                         logic [15:0] od, logic [1:0] os,
                         logic [15:0] cnt);
    string p;
    p = (m == 0) ? "rr" : "fx";
    chk({p, "_in_ready"}, 32'(rdy), 32'(exp_rdy(m)));
    chk({p, "_out_valid"}, 32'(ov), 32'(mv[m]));
    chk({p, "_out_data"}, 32'(od), 32'(md[m]));
    chk({p, "_out_sel"}, 32'(os), 32'(ms[m]));
    chk({p, "_xfer_cnt"}, 32'(cnt), 32'(mcnt[m]));
  endtask

  // Called at the negedge: compare to model, then advance one clock.
  task automatic model_step();
    if (mchk) begin
      chk_dut(0, rdy_rr, ov_rr, od_rr, os_rr, cnt_rr);
      chk_dut(1, rdy_fx, ov_fx, od_fx, os_fx, cnt_fx);
    end
    @(posedge clk);
    model_upd();
    #1;
  endtask

  task automatic cyc();
    @(negedge clk);
    model_step();
  endtask

  task automatic drive(logic r, logic [3:0] v, logic o);
    rst_n = r; in_valid = v; out_ready = o;
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  vld;
    logic        ordy;
    logic [3:0]  rdy_rr;
    logic        ov;
    logic [1:0]  sel;
    logic [15:0] data;
    logic [15:0] cnt;
    logic [3:0]  rdy_fx;
  } vec_t;

  vec_t tbl [12];

  initial begin
    tbl[0]  = '{1'b0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 16'h0000, 16'd0, 4'h0};
    tbl[1]  = '{1'b1, 4'hF, 1'b1, 4'h1, 1'b0, 2'd0, 16'h0000, 16'd0, 4'h1};
    tbl[2]  = '{1'b1, 4'hF, 1'b1, 4'h2, 1'b1, 2'd0, 16'hA000, 16'd0, 4'h1};
    tbl[3]  = '{1'b1, 4'hF, 1'b1, 4'h4, 1'b1, 2'd1, 16'hA001, 16'd1, 4'h1};
    tbl[4]  = '{1'b1, 4'hF, 1'b1, 4'h8, 1'b1, 2'd2, 16'hA002, 16'd2, 4'h1};
    tbl[5]  = '{1'b1, 4'hF, 1'b1, 4'h1, 1'b1, 2'd3, 16'hA003, 16'd3, 4'h1};
    tbl[6]  = '{1'b1, 4'hF, 1'b0, 4'h0, 1'b1, 2'd0, 16'hA000, 16'd4, 4'h0};
    tbl[7]  = '{1'b1, 4'hF, 1'b0, 4'h0, 1'b1, 2'd0, 16'hA000, 16'd4, 4'h0};
    tbl[8]  = '{1'b1, 4'hF, 1'b0, 4'h0, 1'b1, 2'd0, 16'hA000, 16'd4, 4'h0};
    tbl[9]  = '{1'b1, 4'hF, 1'b1, 4'h2, 1'b1, 2'd0, 16'hA000, 16'd4, 4'h1};
    tbl[10] = '{1'b1, 4'h0, 1'b1, 4'h0, 1'b1, 2'd1, 16'hA001, 16'd5, 4'h0};
    tbl[11] = '{1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 2'd1, 16'hA001, 16'd6, 4'h0};

    in_data = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    drive(1'b0, 4'hF, 1'b1);
    model_reset();
    cyc();
    mchk = 1'b1;

    // Reset, RR fairness, backpressure with same-cycle reload
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].rst, tbl[i].vld, tbl[i].ordy);
      @(negedge clk);
      chk($sformatf("tbl%0d_rdy_rr", i), 32'(rdy_rr), 32'(tbl[i].rdy_rr));
      chk($sformatf("tbl%0d_ov", i), 32'(ov_rr), 32'(tbl[i].ov));
      chk($sformatf("tbl%0d_sel", i), 32'(os_rr), 32'(tbl[i].sel));
      chk($sformatf("tbl%0d_data", i), 32'(od_rr), 32'(tbl[i].data));
      chk($sformatf("tbl%0d_cnt", i), 32'(cnt_rr), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_rdy_fx", i), 32'(rdy_fx), 32'(tbl[i].rdy_fx));
      model_step();
    end

    // Fixed priority: ch1 always wins over ch3 until it drops
    drive(1'b1, 4'b1010, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("fx_prio_ch1", 32'(rdy_fx), 32'h2);
      model_step();
    end
    drive(1'b1, 4'b1000, 1'b1);
    @(negedge clk);
    chk("fx_ch3_after_drop", 32'(rdy_fx), 32'h8);
    model_step();

    // Wrap: put rr_ptr at 3, then sparse request 0011
    drive(1'b1, 4'b0100, 1'b1);
    @(negedge clk);
    chk("rr_grant_ch2", 32'(rdy_rr), 32'h4);
    model_step();
    drive(1'b1, 4'b0011, 1'b1);
    @(negedge clk);
    chk("rr_wrap_ch0", 32'(rdy_rr), 32'h1);
    model_step();
    @(negedge clk);
    chk("rr_wrap_then_ch1", 32'(rdy_rr), 32'h2);
    chk("rr_wrap_sel0", 32'(os_rr), 32'h0);
    model_step();

    // Reset while FULL drops the held word
    drive(1'b1, 4'b0000, 1'b0);
    @(negedge clk);
    chk("full_before_reset", 32'(ov_rr), 32'h1);
    model_step();
    drive(1'b0, 4'hF, 1'b0);
    @(negedge clk);
    chk("rdy_in_reset", 32'(rdy_rr), 32'h0);
    model_step();
    drive(1'b1, 4'b0000, 1'b0);
    @(negedge clk);
    chk("dropped_ov", 32'(ov_rr), 32'h0);
    chk("dropped_cnt", 32'(cnt_rr), 32'h0);
    model_step();

    // Saturation of the transfer counter
    drive(1'b1, 4'hF, 1'b1);
    for (int i = 0; i < 65540; i++) cyc();
    drive(1'b1, 4'h0, 1'b1);
    @(negedge clk);
    chk("cnt_saturated_rr", 32'(cnt_rr), 32'hFFFF);
    chk("cnt_saturated_fx", 32'(cnt_fx), 32'hFFFF);
    model_step();

    // Random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      rst_n     = ($urandom_range(0, 63) != 0);
      in_valid  = 4'($urandom);
      in_data   = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
